wb_protocol_monitor: RTL and testbench
======================================

# wb_protocol_monitor

Synthesizable Wishbone B4 classic-cycle protocol monitor with transaction statistics. It attaches passively to the Wishbone slave port of the SDRAM controller top. It replaces the bench-only assertion checks with a parametrised, sticky-flag checker that can also be used on silicon debug buses. It never drives the bus.

## Interface
Parameters:
- AW, 26, Wishbone address width
- DW, 32, Wishbone data width
- SEL_W, DW/8, byte-select width
- ACK_TIMEOUT, 16, max sampled edges from strobe to acknowledge (≥2)
- CNT_W, 16, width of statistic counters

Ports:
- wb_clk_i  in  1  Wishbone clock; the only clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  observed cycle
- wb_stb_i  in  1  observed strobe
- wb_we_i  in  1  observed write enable
- wb_adr_i  in  AW  observed address
- wb_sel_i  in  SEL_W  observed byte select
- wb_dat_i  in  DW  observed write data
- wb_ack_i  in  1  observed slave acknowledge
- clr_i  in  1  synchronous clear of flags and statistics
- err_flags_o  out  5  sticky violation flags; bit map under Operation
- err_o  out  1  OR of err_flags_o
- first_err_o  out  3  index+1 of first flag set; 0 = none
- wr_cnt_o  out  CNT_W  completed writes, saturating
- rd_cnt_o  out  CNT_W  completed reads, saturating
- max_lat_o  out  CNT_W  largest completed-transfer latency
- busy_o  out  1  transfer outstanding (state WAIT or HUNG)

## Operation
- States: GUARD (entered on reset), IDLE, WAIT, HUNG.
- GUARD: lasts exactly one edge after reset release. Go to IDLE unconditionally.
- IDLE: on an edge with cyc&stb:
  - with ack: complete with latency 1 and stay in IDLE.
  - without ack: capture we/adr/sel/dat, set lat=1, go to WAIT.
- WAIT: each edge with cyc&stb increments lat.
  - ack: complete with latency lat+1, go to IDLE.
  - lat+1 == ACK_TIMEOUT without ack: set bit4, go to HUNG.
  - stb or cyc low: abort with no count, go to IDLE.
- HUNG: stay until ack or stb/cyc drop, then go to IDLE. No count. A late ack here is not flagged.
- Completion: increments wr_cnt_o if we=1, else rd_cnt_o. max_lat_o = max(max_lat_o, latency). All counters saturate at all-ones.
- Flags, sampled each edge and sticky:
  - bit0 RST: stb or cyc high in GUARD.
  - bit1 STB_NO_CYC: stb=1 with cyc=0.
  - bit2 SPUR_ACK: ack=1 without cyc&stb, in any state except HUNG.
  - bit3 UNSTABLE: we/adr/sel differ from the captured values in WAIT, or dat differs on a write (see Configuration).
  - bit4 TIMEOUT.
- first_err_o: loaded only while it equals 0. If several flags rise on the same edge, the lowest index wins.
- clr_i: zeroes flags, first_err_o, counters and max_lat_o. It does not change state. An event on the same edge as clr_i wins: the flag or counter ends at its new value (e.g. counter = 1).
- Reset mid-transfer: all outputs go to 0 immediately. The transfer is discarded and the monitor re-enters GUARD.

## Timing
- All outputs are registered. Every output is 0 during reset.
- A violation or completion sampled at edge N is visible after edge N.
- busy_o rises after the edge entering WAIT. It falls after the completion or abort edge.
- Back-to-back transfers: stb held across an ack edge starts a new transfer on the next edge. There is no idle cycle and no error.
- Latency arithmetic is CNT_W wide. ACK_TIMEOUT must be < 2^CNT_W.

## Configuration
- WB_MON_STAB_CHK_EN defined: capture registers are present and bit3 is checked as described.
- WB_MON_STAB_CHK_EN undefined: capture registers are removed and bit3 is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset release with stb=1 on the first edge -> err_flags_o=5'b00001, first_err_o=1, err_o=1.
- Write with ack on the 3rd sampled edge, then read with ack on the 1st -> wr_cnt_o=1, rd_cnt_o=1, max_lat_o=3, no flags.
- stb=1, cyc=0 for one edge, and ack on the same edge -> flags 5'b00110, first_err_o=2.
- ACK_TIMEOUT=16, stb held 20 edges with no ack -> bit4 set after the 16th edge, busy_o stays 1 until stb drops, counters stay 0.
- With WB_MON_STAB_CHK_EN, change adr in WAIT -> bit3 set. Without the macro, the same stimulus sets no flag.
- Assert wb_rst_i mid-WAIT with counters at 5 -> all outputs 0 asynchronously. After release, a single clean transfer gives a count of 1.

Source files
------------

// File: rtl/wb_protocol_monitor.sv
// ============================================================================
// Module      : wb_protocol_monitor
// Description : Passive Wishbone B4 classic-cycle checker with sticky
//               violation flags and transfer statistics.
//               Optional macro WB_MON_STAB_CHK_EN enables the request
//               stability check (flag bit3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_protocol_monitor #(
    parameter int AW          = 26,
    parameter int DW          = 32,
    parameter int SEL_W       = DW / 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [AW-1:0]    wb_adr_i,
    input  logic [SEL_W-1:0] wb_sel_i,
    input  logic [DW-1:0]    wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             clr_i,
    output logic [4:0]       err_flags_o,
    output logic             err_o,
    output logic [2:0]       first_err_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] max_lat_o,
    output logic             busy_o
);

    localparam logic [1:0] S_GUARD = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HUNG  = 2'd3;

    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(ACK_TIMEOUT);

    logic [1:0]       r_state, r_state_nxt;
    logic [CNT_W-1:0] r_lat;
    logic [4:0]       r_flags;
    logic             r_err;
    logic [2:0]       r_first;
    logic [CNT_W-1:0] r_wr, r_rd, r_max;
    logic             r_busy;

    logic             w_xfer, w_start, w_done, w_hang, w_unstable, w_busy_nxt;
    logic [CNT_W-1:0] w_lat_inc, w_done_lat;
    logic [4:0]       w_new_flags, w_flags_nxt;
    logic [2:0]       w_first_nxt;
    logic [CNT_W-1:0] w_wr_nxt, w_rd_nxt, w_max_nxt;

    assign w_xfer     = wb_cyc_i & wb_stb_i;
    assign w_lat_inc  = r_lat + c_one;
    assign w_start    = (r_state == S_IDLE) && w_xfer && !wb_ack_i;
    assign w_done     = ((r_state == S_IDLE) || (r_state == S_WAIT)) && w_xfer && wb_ack_i;
    assign w_done_lat = (r_state == S_WAIT) ? w_lat_inc : c_one;
    assign w_hang     = (r_state == S_WAIT) && w_xfer && !wb_ack_i && (w_lat_inc == c_timeout);

`ifdef WB_MON_STAB_CHK_EN
    logic             r_cap_we;
    logic [AW-1:0]    r_cap_adr;
    logic [SEL_W-1:0] r_cap_sel;
    logic [DW-1:0]    r_cap_dat;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cap_we  <= 1'b0;
            r_cap_adr <= '0;
            r_cap_sel <= '0;
            r_cap_dat <= '0;
        end else if (w_start) begin
            r_cap_we  <= wb_we_i;
            r_cap_adr <= wb_adr_i;
            r_cap_sel <= wb_sel_i;
            r_cap_dat <= wb_dat_i;
        end
    end

    // Only a live request is checked; after an abort the master may move on freely.
    assign w_unstable = (r_state == S_WAIT) && w_xfer &&
                        ((wb_we_i != r_cap_we) || (wb_adr_i != r_cap_adr) ||
                         (wb_sel_i != r_cap_sel) || (r_cap_we && (wb_dat_i != r_cap_dat)));
`else
    logic w_unused_stab;
    assign w_unused_stab = ^{wb_adr_i, wb_sel_i, wb_dat_i};
    assign w_unstable    = 1'b0;
`endif

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_GUARD;
        else          r_state <= r_state_nxt;
    end

    // Next-state logic
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            S_GUARD: r_state_nxt = S_IDLE;
            S_IDLE:  if (w_start) r_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_xfer || wb_ack_i) r_state_nxt = S_IDLE;
                else if (w_hang)         r_state_nxt = S_HUNG;
            end
            S_HUNG:  if (!w_xfer || wb_ack_i) r_state_nxt = S_IDLE;
            default: r_state_nxt = S_GUARD;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy_nxt = (r_state_nxt == S_WAIT) || (r_state_nxt == S_HUNG);
    end

    always_comb begin
        w_new_flags[0] = (r_state == S_GUARD) && (wb_stb_i || wb_cyc_i);
        w_new_flags[1] = wb_stb_i && !wb_cyc_i;
        w_new_flags[2] = wb_ack_i && !w_xfer && (r_state != S_HUNG);
        w_new_flags[3] = w_unstable;
        w_new_flags[4] = w_hang;

        // clr_i clears first, so an event on the same edge survives.
        w_flags_nxt = (clr_i ? 5'd0 : r_flags) | w_new_flags;
        w_first_nxt = clr_i ? 3'd0 : r_first;
        if (w_first_nxt == 3'd0) begin
            if      (w_new_flags[0]) w_first_nxt = 3'd1;
            else if (w_new_flags[1]) w_first_nxt = 3'd2;
            else if (w_new_flags[2]) w_first_nxt = 3'd3;
            else if (w_new_flags[3]) w_first_nxt = 3'd4;
            else if (w_new_flags[4]) w_first_nxt = 3'd5;
        end

        w_wr_nxt  = clr_i ? '0 : r_wr;
        w_rd_nxt  = clr_i ? '0 : r_rd;
        w_max_nxt = clr_i ? '0 : r_max;
        if (w_done) begin
            if (wb_we_i) begin
                if (w_wr_nxt != '1) w_wr_nxt = w_wr_nxt + c_one;
            end else begin
                if (w_rd_nxt != '1) w_rd_nxt = w_rd_nxt + c_one;
            end
            if (w_done_lat > w_max_nxt) w_max_nxt = w_done_lat;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_lat   <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
            r_first <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_max   <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_start)                               r_lat <= c_one;
            else if ((r_state == S_WAIT) && w_xfer)    r_lat <= w_lat_inc;
            r_flags <= w_flags_nxt;
            r_err   <= |w_flags_nxt;
            r_first <= w_first_nxt;
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_max   <= w_max_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign err_flags_o = r_flags;
    assign err_o       = r_err;
    assign first_err_o = r_first;
    assign wr_cnt_o    = r_wr;
    assign rd_cnt_o    = r_rd;
    assign max_lat_o   = r_max;
    assign busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_wb_protocol_monitor.sv
// ============================================================================
// Module      : tb_wb_protocol_monitor
// Description : Directed vector bench for wb_protocol_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_protocol_monitor;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 16;

`ifdef WB_MON_STAB_CHK_EN
    localparam logic [4:0] c_stab_flags = 5'b01000;
    localparam logic [2:0] c_stab_first = 3'd4;
`else
    localparam logic [4:0] c_stab_flags = 5'b00000;
    localparam logic [2:0] c_stab_first = 3'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [SW-1:0] sel = '0;
    logic [DW-1:0] dat = '0;
    logic [4:0]    err_flags;
    logic          err;
    logic [2:0]    first_err;
    logic [CW-1:0] wr_cnt, rd_cnt, max_lat;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_protocol_monitor #(.AW(AW), .DW(DW), .SEL_W(SW), .ACK_TIMEOUT(16), .CNT_W(CW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_dat_i   (dat),
        .wb_ack_i   (ack),
        .clr_i      (clr),
        .err_flags_o(err_flags),
        .err_o      (err),
        .first_err_o(first_err),
        .wr_cnt_o   (wr_cnt),
        .rd_cnt_o   (rd_cnt),
        .max_lat_o  (max_lat),
        .busy_o     (busy)
    );

    typedef struct packed {
        logic          cyc, stb, we, ack, clr;
        logic [AW-1:0] adr;
        logic [4:0]    eflags;
        logic [2:0]    efirst;
        logic [CW-1:0] ewr, erd, emax;
        logic          ebusy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic c, s, w, a, cl, input logic [AW-1:0] ad,
                                input logic [4:0] f, input logic [2:0] fi,
                                input int ew, er, em, input logic eb);
        vec_t v;
        v.cyc = c; v.stb = s; v.we = w; v.ack = a; v.clr = cl; v.adr = ad;
        v.eflags = f; v.efirst = fi;
        v.ewr = CW'(ew); v.erd = CW'(er); v.emax = CW'(em); v.ebusy = eb;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [4:0] ef, input logic [2:0] efi,
                         input int ew, er, em, input logic eb);
        logic [57:0] got, exp;
        got = {err_flags, err, first_err, wr_cnt, rd_cnt, max_lat, busy};
        exp = {ef, |ef, efi, CW'(ew), CW'(er), CW'(em), eb};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got flags=%b err=%b first=%0d wr=%0d rd=%0d max=%0d busy=%b; expected flags=%b err=%b first=%0d wr=%0d rd=%0d max=%0d busy=%b",
                     nm, idx, err_flags, err, first_err, wr_cnt, rd_cnt, max_lat, busy,
                     ef, |ef, efi, ew, er, em, eb);
        end
    endtask

    task automatic drive(input logic c, s, w, a, cl, input logic [AW-1:0] ad);
        cyc = c; stb = s; we = w; ack = a; clr = cl; adr = ad;
        sel = 4'hF; dat = 32'hCAFE_0000 | 32'(ad);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                 cyc stb we ack clr adr      flags     first wr rd max busy
        vecs[0]  = mk(0, 0, 0, 0, 1, 26'h0,   5'b00000, 3'd0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 26'h100, 5'b00000, 3'd0, 0, 0, 0, 1);
        vecs[2]  = mk(1, 1, 1, 0, 0, 26'h100, 5'b00000, 3'd0, 0, 0, 0, 1);
        vecs[3]  = mk(1, 1, 1, 1, 0, 26'h100, 5'b00000, 3'd0, 1, 0, 3, 0);
        vecs[4]  = mk(1, 1, 0, 1, 0, 26'h104, 5'b00000, 3'd0, 1, 1, 3, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 26'h0,   5'b00000, 3'd0, 1, 1, 3, 0);
        vecs[6]  = mk(0, 1, 0, 1, 0, 26'h0,   5'b00110, 3'd2, 1, 1, 3, 0);
        vecs[7]  = mk(1, 1, 0, 1, 1, 26'h108, 5'b00000, 3'd0, 0, 1, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 26'h0,   5'b00000, 3'd0, 0, 1, 1, 0);
        vecs[9]  = mk(1, 1, 1, 0, 0, 26'h10C, 5'b00000, 3'd0, 0, 1, 1, 1);
        vecs[10] = mk(1, 0, 1, 0, 0, 26'h10C, 5'b00000, 3'd0, 0, 1, 1, 0);
        vecs[11] = mk(1, 1, 1, 0, 0, 26'h110, 5'b00000, 3'd0, 0, 1, 1, 1);
        vecs[12] = mk(1, 1, 1, 1, 0, 26'h110, 5'b00000, 3'd0, 1, 1, 2, 0);
        vecs[13] = mk(1, 1, 0, 0, 0, 26'h114, 5'b00000, 3'd0, 1, 1, 2, 1);
        vecs[14] = mk(1, 1, 0, 1, 0, 26'h114, 5'b00000, 3'd0, 1, 2, 2, 0);
        vecs[15] = mk(0, 0, 0, 1, 0, 26'h0,   5'b00100, 3'd3, 1, 2, 2, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 26'h0,   5'b00000, 3'd0, 0, 0, 0, 0);

        // Reset, then release with a live request on the guard edge.
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", 0, 5'b0, 3'd0, 0, 0, 0, 1'b0);
        drive(1, 1, 0, 0, 0, 26'h0);
        rst = 1'b0;
        tick();
        check("guard_req", 0, 5'b00001, 3'd1, 0, 0, 0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].ack, vecs[i].clr, vecs[i].adr);
            tick();
            check("vec", i, vecs[i].eflags, vecs[i].efirst, int'(vecs[i].ewr), int'(vecs[i].erd),
                  int'(vecs[i].emax), vecs[i].ebusy);
        end

        // Timeout: request held 20 edges without acknowledge.
        drive(1, 1, 0, 0, 0, 26'h200);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("timeout", k, (k >= 16) ? 5'b10000 : 5'b00000, (k >= 16) ? 3'd5 : 3'd0, 0, 0, 0, 1'b1);
        end
        // Late ack while hung with the strobe dropping is not flagged.
        drive(0, 0, 0, 1, 0, 26'h0);
        tick();
        check("hung_exit", 0, 5'b10000, 3'd5, 0, 0, 0, 1'b0);

        // Address change while waiting.
        drive(0, 0, 0, 0, 1, 26'h0);
        tick();
        check("clr", 1, 5'b0, 3'd0, 0, 0, 0, 1'b0);
        drive(1, 1, 1, 0, 0, 26'h300);
        tick();
        check("stab", 0, 5'b0, 3'd0, 0, 0, 0, 1'b1);
        drive(1, 1, 1, 0, 0, 26'h304);
        tick();
        check("stab", 1, c_stab_flags, c_stab_first, 0, 0, 0, 1'b1);
        drive(1, 1, 1, 1, 0, 26'h304);
        tick();
        check("stab", 2, c_stab_flags, c_stab_first, 1, 0, 3, 1'b0);

        // Reset in the middle of a wait with counters at 5.
        drive(0, 0, 0, 0, 1, 26'h0);
        tick();
        drive(1, 1, 1, 1, 0, 26'h400);
        repeat (5) tick();
        check("five_wr", 0, 5'b0, 3'd0, 5, 0, 1, 1'b0);
        drive(0, 0, 0, 0, 0, 26'h0);
        tick();
        drive(1, 1, 1, 0, 0, 26'h404);
        tick();
        check("pre_rst", 0, 5'b0, 3'd0, 5, 0, 1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 0, 5'b0, 3'd0, 0, 0, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 26'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_guard", 0, 5'b0, 3'd0, 0, 0, 0, 1'b0);
        drive(1, 1, 1, 1, 0, 26'h408);
        tick();
        check("post_rst_wr", 0, 5'b0, 3'd0, 1, 0, 1, 1'b0);
        drive(0, 0, 0, 0, 0, 26'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
